uart_rx: RTL and testbench

//   8N1 UART receiver; the receive-side counterpart of uart_tx on the same serial link.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud-timing helpers.
// Used by both the receiver (uart_rx) and the transmitter (uart_tx).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned CNT_W = 16;

  function automatic int unsigned calc_bit_period(input int unsigned clock_freq,
                                                  input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_half_period(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return calc_bit_period(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high and idle-low lines can share it.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_reg <= RESET_VALUE;
      sync_reg <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, stop-bit check and 1-cycle result pulses.
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote over recent rx history.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 96000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int unsigned BIT_PERIOD  = calc_bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_PERIOD = calc_half_period(CLOCK_FREQ, BAUD_RATE);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);

  logic             rx_s;
  logic             rx_prev_reg;
  logic             sample;
  uart_state_t      state_reg;
  logic [CNT_W-1:0] counter_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       data_reg;
  logic             valid_reg;
  logic             framing_err_reg;
  logic             busy_reg;

  uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous rx_s values plus the current one form the 3-sample voting window.
  logic [1:0] hist_reg;

  always_ff @(posedge clk) begin
    if (!reset) hist_reg <= 2'b11;
    else        hist_reg <= {hist_reg[0], rx_s};
  end

  assign sample = (rx_s & hist_reg[0]) | (rx_s & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_prev_reg     <= 1'b1;
      state_reg       <= IDLE;
      counter_reg     <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      framing_err_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      rx_prev_reg     <= rx_s;
      valid_reg       <= 1'b0;
      framing_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Only a falling edge starts a frame, so a held-low break never re-triggers.
          if (!rx_s && rx_prev_reg) begin
            state_reg   <= START;
            counter_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        START: begin
          if (counter_reg == HALF_LAST) begin
            counter_reg <= '0;
            bit_idx_reg <= '0;
            if (sample) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= DATA;
            end
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        DATA: begin
          if (counter_reg == BIT_LAST) begin
            counter_reg <= '0;
            shift_reg   <= {sample, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        STOP: begin
          if (counter_reg == BIT_LAST) begin
            counter_reg <= '0;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            if (sample) begin
              data_reg  <= shift_reg;
              valid_reg <= 1'b1;
            end else begin
              framing_err_reg <= 1'b1;
            end
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign data        = data_reg;
  assign valid       = valid_reg;
  assign framing_err = framing_err_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial transmitter drives rx and
// expected bytes/pulse timing come from the 8N1 framing rules.
module tb_uart_rx;

  localparam int BP    = 96000 / 9600;
  localparam int HALF  = BP / 2;
  localparam int FRAME = 10 * BP;
  localparam int LAT   = 2 + HALF + 9 * BP;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       busy;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         stray = 0;
  logic [7:0] last_good = 8'h00;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  // Sends start + 8 data bits (LSB first) + stop; glitch_e inverts rx for one cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_e,
                            output int n_valid, output int n_ferr, output int n_both,
                            output int pulse_e, output logic [7:0] pulse_data,
                            output logic pulse_busy);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    n_valid = 0; n_ferr = 0; n_both = 0; pulse_e = -1; pulse_data = 8'h00; pulse_busy = 1'b1;
    for (int e = 0; e < FRAME; e++) begin
      @(negedge clk);
      rx = bits[e / BP] ^ (e == glitch_e);
      @(posedge clk);
      #1;
      if (valid) n_valid++;
      if (framing_err) n_ferr++;
      if (valid && framing_err) n_both++;
      if (valid || framing_err) begin
        pulse_e = e; pulse_data = data; pulse_busy = busy;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
      @(posedge clk);
      #1;
      if (valid || framing_err) stray++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", data); end
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests_run++; if (framing_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b expected 0", framing_err); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    idle(5);
  endtask

  task automatic test_loopback();
    int nv, nf, nb, pe; logic [7:0] pd; logic pb;
    send_frame(8'hA5, 1'b1, -1, nv, nf, nb, pe, pd, pb);
    tests_run++; if (nv !== 1) begin tests_failed++; $display("FAIL loop_valid_count: got %0d expected 1", nv); end
    tests_run++; if (nf !== 0) begin tests_failed++; $display("FAIL loop_ferr_count: got %0d expected 0", nf); end
    tests_run++; if (pd !== 8'hA5) begin tests_failed++; $display("FAIL loop_data: got %h expected a5", pd); end
    tests_run++; if (pe !== LAT) begin tests_failed++; $display("FAIL loop_latency: got %0d expected %0d", pe, LAT); end
    tests_run++; if (pb !== 1'b0) begin tests_failed++; $display("FAIL loop_busy_at_valid: got %b expected 0", pb); end
    last_good = 8'hA5;
    idle(20);
    tests_run++; if (data !== 8'hA5) begin tests_failed++; $display("FAIL loop_data_held: got %h expected a5", data); end
  endtask

  task automatic test_back_to_back();
    int nv, nf, nb, pe; logic [7:0] pd; logic pb;
    logic [7:0] seq [2];
    seq[0] = 8'h00; seq[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      send_frame(seq[i], 1'b1, -1, nv, nf, nb, pe, pd, pb);
      tests_run++; if (nv !== 1) begin tests_failed++; $display("FAIL b2b_valid_count[%0d]: got %0d expected 1", i, nv); end
      tests_run++; if (pd !== seq[i]) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, pd, seq[i]); end
      last_good = seq[i];
    end
    idle(20);
  endtask

  task automatic test_glitch_start();
    logic busy2, busy9; int pulses;
    busy2 = 1'b0; busy9 = 1'b1; pulses = 0;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      rx = (e < 3) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (e == 2) busy2 = busy;
      if (e == 9) busy9 = busy;
      if (valid || framing_err) pulses++;
    end
    tests_run++; if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_high: got %b expected 1", busy2); end
    tests_run++; if (busy9 !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_low: got %b expected 0", busy9); end
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_framing();
    int nv, nf, nb, pe; logic [7:0] pd; logic pb;
    send_frame(8'h5A, 1'b0, -1, nv, nf, nb, pe, pd, pb);
    tests_run++; if (nf !== 1) begin tests_failed++; $display("FAIL ferr_count: got %0d expected 1", nf); end
    tests_run++; if (nv !== 0) begin tests_failed++; $display("FAIL ferr_valid_count: got %0d expected 0", nv); end
    tests_run++; if (pd !== last_good) begin tests_failed++; $display("FAIL ferr_data_kept: got %h expected %h", pd, last_good); end
    tests_run++; if (pe !== LAT) begin tests_failed++; $display("FAIL ferr_latency: got %0d expected %0d", pe, LAT); end
    idle(10);
    send_frame(8'h3C, 1'b1, -1, nv, nf, nb, pe, pd, pb);
    tests_run++; if (nv !== 1 || pd !== 8'h3C) begin tests_failed++; $display("FAIL ferr_recover: got %0d pulses data %h expected 1 pulse data 3c", nv, pd); end
    last_good = 8'h3C;
    idle(10);
  endtask

  task automatic test_reset_mid_frame();
    int nv, nf, nb, pe; logic [7:0] pd; logic pb; logic busy_before;
    logic [9:0] bits;
    bits = {1'b1, 8'h81, 1'b0};
    busy_before = 1'b0;
    // Abort partway through data bit 4 (frame bit index 5).
    for (int e = 0; e < 5 * BP + 4; e++) begin
      @(negedge clk);
      rx = bits[e / BP];
      @(posedge clk);
      #1;
      busy_before = busy;
      if (valid || framing_err) stray++;
    end
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1;
    tests_run++; if (busy_before !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy_before: got %b expected 1", busy_before); end
    tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL midrst_data: got %h expected 00", data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests_run++; if (valid !== 1'b0 || framing_err !== 1'b0) begin tests_failed++; $display("FAIL midrst_pulses: got %b%b expected 00", valid, framing_err); end
    @(negedge clk);
    reset = 1'b1;
    last_good = 8'h00;
    idle(20);
    send_frame(8'h42, 1'b1, -1, nv, nf, nb, pe, pd, pb);
    tests_run++; if (nv !== 1 || pd !== 8'h42) begin tests_failed++; $display("FAIL midrst_next: got %0d pulses data %h expected 1 pulse data 42", nv, pd); end
    last_good = 8'h42;
    idle(10);
  endtask

  task automatic test_glitch_bit();
    int nv, nf, nb, pe; logic [7:0] pd; logic pb; logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'hF0;
`else
    exp = 8'hF8;
`endif
    send_frame(8'hF0, 1'b1, 4 * BP + HALF, nv, nf, nb, pe, pd, pb);
    tests_run++; if (nv !== 1) begin tests_failed++; $display("FAIL bitglitch_valid_count: got %0d expected 1", nv); end
    tests_run++; if (pd !== exp) begin tests_failed++; $display("FAIL bitglitch_data: got %h expected %h", pd, exp); end
    last_good = exp;
    idle(10);
  endtask

  task automatic test_random();
    int nv, nf, nb, pe; logic [7:0] pd; logic pb;
    logic [7:0] b; logic stop_bit; int gap;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(255, 0));
      stop_bit = ($urandom_range(3, 0) != 0);
      send_frame(b, stop_bit, -1, nv, nf, nb, pe, pd, pb);
      tests_run++; if (nb !== 0) begin tests_failed++; $display("FAIL rand_overlap[%0d]: got %0d expected 0", i, nb); end
      if (stop_bit) begin
        tests_run++; if (nv !== 1 || nf !== 0 || pd !== b || pe !== LAT) begin
          tests_failed++;
          $display("FAIL rand_good[%0d]: got v=%0d f=%0d data=%h at %0d expected v=1 f=0 data=%h at %0d", i, nv, nf, pd, pe, b, LAT);
        end
        last_good = b;
      end else begin
        tests_run++; if (nv !== 0 || nf !== 1 || pd !== last_good || pe !== LAT) begin
          tests_failed++;
          $display("FAIL rand_ferr[%0d]: got v=%0d f=%0d data=%h at %0d expected v=0 f=1 data=%h at %0d", i, nv, nf, pd, pe, last_good, LAT);
        end
      end
      // A framing error leaves the line low, so at least one idle cycle is needed for a new falling edge.
      gap = stop_bit ? int'($urandom_range(15, 0)) : int'($urandom_range(15, 1));
      idle(gap);
    end
    idle(20);
    tests_run++; if (data !== last_good) begin tests_failed++; $display("FAIL rand_data_held: got %h expected %h", data, last_good); end
  endtask

  task automatic test_no_stray();
    tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL stray_pulses: got %0d expected 0", stray); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch_start();
    test_framing();
    test_reset_mid_frame();
    test_glitch_bit();
    test_random();
    test_no_stray();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
